// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//
// Upstream stage of the reconfigurable transposed FIR filter. It accepts a
// burst of signed coefficients over a valid/ready handshake and buffers them
// in a small FIFO. It then writes them one per cycle into four coefficient
// RAM banks. The whole update window is bracketed with oCoeffiUpdateFlag.
//
// Optional feature: define CHECKSUM_EN to add oChecksum. oChecksum is the
// running modulo-2^16 sum of the coefficients written in the current load.
//
// Ports:
//   iClk_12M          system clock
//   iRsn              asynchronous active-low reset
//   iLoadStart        one-cycle load request (sampled only in IDLE)
//   iNumOfCoeff       tap count for the load (legal 1..MAX_COEFF)
//   iCoeffValid       coefficient valid
//   iCoeffData        signed coefficient
//   oCoeffReady       FIFO can take a coefficient
//   oCoeffiUpdateFlag high from ARM through DONE
//   oCsnRam, oWrnRam  active-low RAM chip select / write strobe
//   oBankSel          target bank 0..3
//   oAddrRam          local address 1..BANK_SIZE
//   oWrDtRam          write data
//   oNumOfCoeff       latched tap count
//   oBusy             FSM not in IDLE
//   oLoadDone         one-cycle completion pulse
//   oLoadErr          one-cycle pulse on a rejected start request
//   oChecksum         (CHECKSUM_EN only) running sum of written coefficients
`timescale 1ns/1ps

module fir_coeff_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_COEFF  = 33,
    parameter int BANK_SIZE  = 10,
    parameter int COEF_W     = 16
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iLoadStart,
    input  logic [5:0]               iNumOfCoeff,
    input  logic                     iCoeffValid,
    input  logic signed [COEF_W-1:0] iCoeffData,
    output logic                     oCoeffReady,
    output logic                     oCoeffiUpdateFlag,
    output logic                     oCsnRam,
    output logic                     oWrnRam,
    output logic [1:0]               oBankSel,
    output logic [3:0]               oAddrRam,
    output logic signed [COEF_W-1:0] oWrDtRam,
    output logic [5:0]               oNumOfCoeff,
    output logic                     oBusy,
    output logic                     oLoadDone,
`ifdef CHECKSUM_EN
    output logic [15:0]              oChecksum,
`endif
    output logic                     oLoadErr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [5:0]       MAX_N     = 6'(MAX_COEFF);
    localparam logic [3:0]       LAST_ADDR = 4'(BANK_SIZE);

    typedef enum logic [1:0] {IDLE, ARM, WRITE, DONE} state_t;

    state_t state;

    logic signed [COEF_W-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] fifoCnt;
    logic [5:0]       acceptCnt;
    logic [5:0]       writeCnt;
    logic [1:0]       nextBank;
    logic [3:0]       nextAddr;
    logic             push;
    logic             pop;
    logic signed [COEF_W-1:0] popData;

    // Wrap the local address back to 1 once a bank is full.
    function automatic logic [3:0] advanceAddr(input logic [3:0] addr);
        return (addr == LAST_ADDR) ? 4'd1 : addr + 4'd1;
    endfunction

    // Ready depends only on registered state. A full FIFO therefore never
    // sees a push in the same cycle as a pop.
    assign oCoeffReady = ((state == ARM) || (state == WRITE)) &&
                         (fifoCnt != FULL_CNT) && (acceptCnt < oNumOfCoeff);
    assign push    = iCoeffValid && oCoeffReady;
    assign pop     = (state == WRITE) && (fifoCnt != '0);
    assign popData = fifoMem[rdPtr];

    // ---- stage p0: FIFO storage (data only, no reset) ----
    always_ff @(posedge iClk_12M) begin
        if (push) begin
            fifoMem[wrPtr] <= iCoeffData;
        end
    end

    // ---- stage p1: control FSM and registered RAM interface ----
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state             <= IDLE;
            wrPtr             <= '0;
            rdPtr             <= '0;
            fifoCnt           <= '0;
            acceptCnt         <= '0;
            writeCnt          <= '0;
            nextBank          <= '0;
            nextAddr          <= 4'd1;
            oCoeffiUpdateFlag <= 1'b0;
            oCsnRam           <= 1'b1;
            oWrnRam           <= 1'b1;
            oBankSel          <= '0;
            oAddrRam          <= 4'd1;
            oWrDtRam          <= '0;
            oNumOfCoeff       <= '0;
            oBusy             <= 1'b0;
            oLoadDone         <= 1'b0;
            oLoadErr          <= 1'b0;
`ifdef CHECKSUM_EN
            oChecksum         <= '0;
`endif
        end else begin
            oLoadDone <= 1'b0;
            oLoadErr  <= 1'b0;

            if (push) begin
                wrPtr     <= wrPtr + 1'b1;
                acceptCnt <= acceptCnt + 6'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCnt <= fifoCnt + 1'b1;
                2'b01:   fifoCnt <= fifoCnt - 1'b1;
                default: fifoCnt <= fifoCnt;
            endcase

            case (state)
                IDLE: begin
                    if (iLoadStart) begin
                        if ((iNumOfCoeff != 6'd0) && (iNumOfCoeff <= MAX_N)) begin
                            state             <= ARM;
                            oNumOfCoeff       <= iNumOfCoeff;
                            oCoeffiUpdateFlag <= 1'b1;
                            oBusy             <= 1'b1;
                            acceptCnt         <= '0;
                            writeCnt          <= '0;
                            nextBank          <= '0;
                            nextAddr          <= 4'd1;
`ifdef CHECKSUM_EN
                            oChecksum         <= '0;
`endif
                        end else begin
                            oLoadErr <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    state <= WRITE;
                end
                WRITE: begin
                    if (pop) begin
                        oCsnRam  <= 1'b0;
                        oWrnRam  <= 1'b0;
                        oWrDtRam <= popData;
                        oBankSel <= nextBank;
                        oAddrRam <= nextAddr;
                        nextAddr <= advanceAddr(nextAddr);
                        if (nextAddr == LAST_ADDR) begin
                            nextBank <= nextBank + 2'd1;
                        end
                        writeCnt <= writeCnt + 6'd1;
`ifdef CHECKSUM_EN
                        oChecksum <= oChecksum + $unsigned(popData);
`endif
                        if (writeCnt + 6'd1 == oNumOfCoeff) begin
                            state <= DONE;
                        end
                    end else begin
                        // Upstream gap: deselect the RAM, hold address/data.
                        oCsnRam <= 1'b1;
                        oWrnRam <= 1'b1;
                    end
                end
                DONE: begin
                    oCsnRam           <= 1'b1;
                    oWrnRam           <= 1'b1;
                    oLoadDone         <= 1'b1;
                    oCoeffiUpdateFlag <= 1'b0;
                    oBusy             <= 1'b0;
                    acceptCnt         <= '0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps

module tb_fir_coeff_loader;

    logic        iClk_12M;
    logic        iRsn;
    logic        iLoadStart;
    logic [5:0]  iNumOfCoeff;
    logic        iCoeffValid;
    logic [15:0] iCoeffData;
    logic        oCoeffReady;
    logic        oCoeffiUpdateFlag;
    logic        oCsnRam;
    logic        oWrnRam;
    logic [1:0]  oBankSel;
    logic [3:0]  oAddrRam;
    logic [15:0] oWrDtRam;
    logic [5:0]  oNumOfCoeff;
    logic        oBusy;
    logic        oLoadDone;
    logic        oLoadErr;
`ifdef CHECKSUM_EN
    logic [15:0] oChecksum;
`endif

    fir_coeff_loader dut (
        .iClk_12M          (iClk_12M),
        .iRsn              (iRsn),
        .iLoadStart        (iLoadStart),
        .iNumOfCoeff       (iNumOfCoeff),
        .iCoeffValid       (iCoeffValid),
        .iCoeffData        (iCoeffData),
        .oCoeffReady       (oCoeffReady),
        .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
        .oCsnRam           (oCsnRam),
        .oWrnRam           (oWrnRam),
        .oBankSel          (oBankSel),
        .oAddrRam          (oAddrRam),
        .oWrDtRam          (oWrDtRam),
        .oNumOfCoeff       (oNumOfCoeff),
        .oBusy             (oBusy),
        .oLoadDone         (oLoadDone),
`ifdef CHECKSUM_EN
        .oChecksum         (oChecksum),
`endif
        .oLoadErr          (oLoadErr)
    );

    initial iClk_12M = 1'b0;
    always #41 iClk_12M = ~iClk_12M;

    int checks = 0;
    int errors = 0;

    logic [15:0] coef [0:63];
    logic [1:0]  wrBank [$];
    logic [3:0]  wrAddr [$];
    logic [15:0] wrData [$];
    int          wrCyc  [$];
    int          flagCnt;
    int          doneCycle;
    int          errDuring;
    int          busyAtDone;
    logic [5:0]  numSeen;
    logic [15:0] sumAtDone;
    logic        ended;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Start a load of n taps and stream coef[0..n-1]. Sampling is done on
    // the falling edge. With stopAfter > 0 the task returns, at a falling
    // edge, as soon as that many writes have been seen.
    task automatic runLoad(input int n, input bit gaps, input int stopAfter);
        int idx;
        int cyc;
        bit acc;
        wrBank.delete(); wrAddr.delete(); wrData.delete(); wrCyc.delete();
        flagCnt = 0; doneCycle = -1; errDuring = 0; busyAtDone = -1;
        numSeen = '0; sumAtDone = '0; ended = 1'b0;
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b1; iNumOfCoeff = 6'(n);
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b0;
        idx = 0; cyc = 0;
        while (!ended && cyc < 300) begin
            // A bogus start while busy must be ignored silently.
            iLoadStart = (cyc == 3);
            if (cyc == 3) iNumOfCoeff = 6'd0;
            iCoeffValid = (idx < n) && (!gaps || (cyc % 2 == 0));
            iCoeffData  = (idx < n) ? coef[idx] : 16'h0;
            @(negedge iClk_12M);
            if (cyc == 0) numSeen = oNumOfCoeff;
            if (!oCsnRam && !oWrnRam) begin
                wrBank.push_back(oBankSel);
                wrAddr.push_back(oAddrRam);
                wrData.push_back(oWrDtRam);
                wrCyc.push_back(cyc);
            end
            if (oCoeffiUpdateFlag) flagCnt++;
            if (oLoadErr) errDuring++;
            if (oLoadDone) begin
                doneCycle  = cyc;
                busyAtDone = int'(oBusy);
`ifdef CHECKSUM_EN
                sumAtDone  = oChecksum;
`endif
                ended = 1'b1;
            end
            if (stopAfter > 0 && wrData.size() >= stopAfter) ended = 1'b1;
            acc = iCoeffValid && oCoeffReady;
            if (!ended) begin
                @(posedge iClk_12M); #1;
                if (acc) idx++;
                cyc++;
            end
        end
        iLoadStart  = 1'b0;
        iCoeffValid = 1'b0;
        checkVal("loadEnded", 32'(ended), 32'd1);
    endtask

    task automatic startErr(input logic [5:0] n);
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b1; iNumOfCoeff = n;
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b0;
        @(negedge iClk_12M);
        checkVal("errPulse", 32'(oLoadErr), 32'd1);
        checkVal("errBusy", 32'(oBusy), 32'd0);
        checkVal("errFlag", 32'(oCoeffiUpdateFlag), 32'd0);
        @(negedge iClk_12M);
        checkVal("errPulseEnd", 32'(oLoadErr), 32'd0);
        checkVal("errBusy2", 32'(oBusy), 32'd0);
        checkVal("errFlag2", 32'(oCoeffiUpdateFlag), 32'd0);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkVal({pfx, "Csn"},   32'(oCsnRam), 32'd1);
        checkVal({pfx, "Wrn"},   32'(oWrnRam), 32'd1);
        checkVal({pfx, "Addr"},  32'(oAddrRam), 32'd1);
        checkVal({pfx, "Bank"},  32'(oBankSel), 32'd0);
        checkVal({pfx, "Data"},  32'(oWrDtRam), 32'd0);
        checkVal({pfx, "Flag"},  32'(oCoeffiUpdateFlag), 32'd0);
        checkVal({pfx, "Busy"},  32'(oBusy), 32'd0);
        checkVal({pfx, "Num"},   32'(oNumOfCoeff), 32'd0);
        checkVal({pfx, "Ready"}, 32'(oCoeffReady), 32'd0);
        checkVal({pfx, "Done"},  32'(oLoadDone), 32'd0);
        checkVal({pfx, "Err"},   32'(oLoadErr), 32'd0);
    endtask

    initial begin
        iRsn = 1'b0; iLoadStart = 1'b0; iNumOfCoeff = '0;
        iCoeffValid = 1'b0; iCoeffData = '0;
        repeat (3) @(posedge iClk_12M);
        #1;
        checkResetOutputs("rst");
        @(negedge iClk_12M);
        iRsn = 1'b1;

        // Data offered in IDLE is never accepted.
        @(posedge iClk_12M); #1;
        iCoeffValid = 1'b1; iCoeffData = 16'h5555;
        @(negedge iClk_12M);
        checkVal("readyIdle", 32'(oCoeffReady), 32'd0);
        @(posedge iClk_12M); #1;
        iCoeffValid = 1'b0;

        // N=10, back-to-back 1..10: writes at cycles 2..11, flag 12 cycles.
        for (int k = 0; k < 10; k++) coef[k] = 16'(k + 1);
        runLoad(10, 1'b0, 0);
        checkVal("n10Count", 32'(wrData.size()), 32'd10);
        checkVal("n10Num", 32'(numSeen), 32'd10);
        for (int k = 0; k < 10 && k < wrData.size(); k++) begin
            checkVal($sformatf("n10Bank%0d", k), 32'(wrBank[k]), 32'd0);
            checkVal($sformatf("n10Addr%0d", k), 32'(wrAddr[k]), 32'(k + 1));
            checkVal($sformatf("n10Data%0d", k), 32'(wrData[k]), 32'(k + 1));
        end
        if (wrCyc.size() == 10) begin
            checkVal("n10First", 32'(wrCyc[0]), 32'd2);
            checkVal("n10Last", 32'(wrCyc[9]), 32'd11);
        end
        checkVal("n10Flag", 32'(flagCnt), 32'd12);
        checkVal("n10Done", 32'(doneCycle), 32'd12);
        checkVal("n10BusyAtDone", 32'(busyAtDone), 32'd0);
        checkVal("n10NoErr", 32'(errDuring), 32'd0);
        @(negedge iClk_12M);
        checkVal("n10DoneEnd", 32'(oLoadDone), 32'd0);

        // N=33, data 0x0100+k: bank boundaries and the last tap.
        for (int k = 0; k < 33; k++) coef[k] = 16'h0100 + 16'(k);
        runLoad(33, 1'b0, 0);
        checkVal("n33Count", 32'(wrData.size()), 32'd33);
        if (wrData.size() == 33) begin
            checkVal("n33k9Bank", 32'(wrBank[9]), 32'd0);
            checkVal("n33k9Addr", 32'(wrAddr[9]), 32'd10);
            checkVal("n33k10Bank", 32'(wrBank[10]), 32'd1);
            checkVal("n33k10Addr", 32'(wrAddr[10]), 32'd1);
            checkVal("n33k20Bank", 32'(wrBank[20]), 32'd2);
            checkVal("n33k20Addr", 32'(wrAddr[20]), 32'd1);
            checkVal("n33LastBank", 32'(wrBank[32]), 32'd3);
            checkVal("n33LastAddr", 32'(wrAddr[32]), 32'd3);
            checkVal("n33LastData", 32'(wrData[32]), 32'h0120);
            for (int k = 0; k < 33; k++)
                checkVal($sformatf("n33Data%0d", k), 32'(wrData[k]), 32'h0100 + 32'(k));
        end
        checkVal("n33Flag", 32'(flagCnt), 32'd35);

        // N=5 with valid on even cycles: writes at cycles 2,4,6,8,10.
        for (int k = 0; k < 5; k++) coef[k] = 16'hA000 + 16'(k * 3);
        runLoad(5, 1'b1, 0);
        checkVal("gapCount", 32'(wrData.size()), 32'd5);
        for (int k = 0; k < 5 && k < wrData.size(); k++) begin
            checkVal($sformatf("gapData%0d", k), 32'(wrData[k]), 32'hA000 + 32'(k * 3));
            checkVal($sformatf("gapCyc%0d", k), 32'(wrCyc[k]), 32'(2 + 2 * k));
            checkVal($sformatf("gapAddr%0d", k), 32'(wrAddr[k]), 32'(k + 1));
        end
        checkVal("gapFlag", 32'(flagCnt), 32'd11);
        checkVal("gapNoErr", 32'(errDuring), 32'd0);

        // Rejected start requests: zero, one past the maximum, far out of range.
        startErr(6'd0);
        startErr(6'd34);
        startErr(6'd40);

        // Reset after the 4th write of an N=20 load.
        for (int k = 0; k < 20; k++) coef[k] = 16'h2000 + 16'(k);
        runLoad(20, 1'b0, 4);
        checkVal("rstMidWrites", 32'(wrData.size()), 32'd4);
        iRsn = 1'b0;
        #1;
        checkResetOutputs("rstMid");
        @(posedge iClk_12M);
        @(negedge iClk_12M);
        iRsn = 1'b1;

        coef[0] = 16'h0AAA;
        coef[1] = 16'h0555;
        runLoad(2, 1'b0, 0);
        checkVal("postRstCount", 32'(wrData.size()), 32'd2);
        if (wrData.size() == 2) begin
            checkVal("postRstBank0", 32'(wrBank[0]), 32'd0);
            checkVal("postRstAddr0", 32'(wrAddr[0]), 32'd1);
            checkVal("postRstData0", 32'(wrData[0]), 32'h0AAA);
            checkVal("postRstBank1", 32'(wrBank[1]), 32'd0);
            checkVal("postRstAddr1", 32'(wrAddr[1]), 32'd2);
            checkVal("postRstData1", 32'(wrData[1]), 32'h0555);
        end
        checkVal("postRstFlag", 32'(flagCnt), 32'd4);

`ifdef CHECKSUM_EN
        coef[0] = 16'h7FFF;
        coef[1] = 16'h0002;
        coef[2] = 16'hFFFF;
        runLoad(3, 1'b0, 0);
        checkVal("checksum", 32'(sumAtDone), 32'h8000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
